// File: rtl/fizzbuzz_tx_sequencer.sv
// fizzbuzz_tx_sequencer
// Drives the shared uart_tx with the FizzBuzz stream for 1..MAX_COUNT. Each
// line ends in CR LF. Bytes go out one per valid/busy handshake. Decimal text
// comes from a BCD counter, and divisibility from mod-3/mod-5 counters, so no
// divider is needed.
// Optional feature: define FIZZBUZZ_XON_XOFF_EN to add XON/XOFF flow control
// from uart_rx (ports i_rx_valid, i_rx_data).
module fizzbuzz_tx_sequencer #(
    parameter int MAX_COUNT = 100,
    parameter int DIGITS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_tx_busy,
`ifdef FIZZBUZZ_XON_XOFF_EN
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
`endif
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_busy,
    output logic       o_done
);

    // Longest line is either "FizzBuzz" + CR LF or the widest number + CR LF
    localparam int LINE_MAX = (DIGITS + 2 > 10) ? DIGITS + 2 : 10;
    localparam int IDX_W    = $clog2(LINE_MAX + 1);

    localparam logic [63:0] FIZZBUZZ_STR = "FizzBuzz";
    localparam logic [31:0] FIZZ_STR     = "Fizz";
    localparam logic [31:0] BUZZ_STR     = "Buzz";
    localparam logic [7:0]  CR           = 8'h0D;
    localparam logic [7:0]  LF           = 8'h0A;
    localparam logic [7:0]  XON          = 8'h11;
    localparam logic [7:0]  XOFF         = 8'h13;

    typedef logic [DIGITS-1:0][3:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_IDLE,
        ADVANCE,
        DONE
    } state_t;

    // Elaboration-time binary to BCD conversion for constants
    function automatic bcd_t to_bcd(input int value);
        bcd_t result;
        int   rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < DIGITS; i++) begin
            result[i] = 4'(rest % 10);
            rest      = rest / 10;
        end
        return result;
    endfunction

    // Decimal increment with ripple carry through the digits
    function automatic bcd_t bcd_inc(input bcd_t value);
        bcd_t result;
        logic carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (result[i] == 4'd9) begin
                    result[i] = 4'd0;
                end else begin
                    result[i] = result[i] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
        return result;
    endfunction

    localparam bcd_t ONE_BCD = to_bcd(1);
    localparam bcd_t MAX_BCD = to_bcd(MAX_COUNT);

    state_t           state;
    bcd_t             bcd;
    logic [1:0]       mod3;
    logic [2:0]       mod5;
    logic [IDX_W-1:0] idx;
    logic             paused;

    logic             fizz;
    logic             buzz;
    logic [IDX_W-1:0] num_digits;
    logic [IDX_W-1:0] line_len;
    logic [3:0]       digit;
    logic [7:0]       cur_char;
    logic             last_char;

    assign fizz      = (mod3 == 2'd0);
    assign buzz      = (mod5 == 3'd0);
    assign last_char = (idx == line_len - IDX_W'(1));

    // Significant digit count, taken from the highest nonzero BCD digit
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        num_digits = IDX_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i] != 4'd0) begin
                num_digits = IDX_W'(i + 1);
            end
        end
    end

    // Length of the current line and the character at the current index
    always_comb begin
        cur_char = 8'h00;
        digit    = 4'd0;
        if (fizz && buzz) begin
            line_len = IDX_W'(10);
        end else if (fizz || buzz) begin
            line_len = IDX_W'(6);
        end else begin
            line_len = num_digits + IDX_W'(2);
        end

        // Most significant printed digit sits at index 0
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(num_digits) - 1 - int'(idx) == i) begin
                digit = bcd[i];
            end
        end

        if (idx == line_len - IDX_W'(2)) begin
            cur_char = CR;
        end else if (idx == line_len - IDX_W'(1)) begin
            cur_char = LF;
        end else if (fizz && buzz) begin
            for (int k = 0; k < 8; k++) begin
                if (int'(idx) == k) cur_char = FIZZBUZZ_STR[8*(7-k) +: 8];
            end
        end else if (fizz) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(idx) == k) cur_char = FIZZ_STR[8*(3-k) +: 8];
            end
        end else if (buzz) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(idx) == k) cur_char = BUZZ_STR[8*(3-k) +: 8];
            end
        end else begin
            cur_char = 8'h30 + {4'h0, digit};
        end
    end

    // Sequencer FSM: one strobe per handshake, counters advance after each LF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            bcd        <= ONE_BCD;
            mod3       <= 2'd1;
            mod5       <= 3'd1;
            idx        <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            o_tx_valid <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= SEND;
                        o_busy <= 1'b1;
                        bcd    <= ONE_BCD;
                        mod3   <= 2'd1;
                        mod5   <= 3'd1;
                        idx    <= '0;
                    end
                end
                SEND: begin
                    if (!i_tx_busy && !paused) begin
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= cur_char;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (i_tx_busy) state <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!i_tx_busy) state <= ADVANCE;
                end
                ADVANCE: begin
                    if (!last_char) begin
                        idx   <= idx + IDX_W'(1);
                        state <= SEND;
                    end else if (bcd != MAX_BCD) begin
                        bcd   <= bcd_inc(bcd);
                        mod3  <= (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
                        mod5  <= (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
                        idx   <= '0;
                        state <= SEND;
                    end else begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= ONE_BCD;
                    mod3  <= 2'd1;
                    mod5  <= 3'd1;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIZZBUZZ_XON_XOFF_EN
    // Flow-control flag: XOFF pauses and XON resumes; cleared when the run returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paused <= 1'b0;
        end else if (state == DONE) begin
            paused <= 1'b0;
        end else if (i_rx_valid && i_rx_data == XOFF) begin
            paused <= 1'b1;
        end else if (i_rx_valid && i_rx_data == XON) begin
            paused <= 1'b0;
        end
    end
`else
    assign paused = 1'b0;
`endif

endmodule
